// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns a one-cycle trigger pulse into a level held high for
// a programmable number of cycles, followed by an optional hold-off gap.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   trig       trigger, sampled every rising edge
//   len        level length in cycles, sampled when a trigger is accepted
//   retrig_en  1: a trigger while the level is high reloads the counter
//   level      stretched output (registered)
//   busy       high while the level is high or during hold-off
//   done       one-cycle pulse in the first cycle after the level falls
//   missed     one-cycle pulse in the cycle after an ignored trigger
module pulse_stretcher #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [WIDTH-1:0] len,
    input  logic             retrig_en,
    output logic             level,
    output logic             busy,
    output logic             done,
    output logic             missed
);

    // Gap counter holds at most GAP-1; keep it at least one bit wide.
    localparam int unsigned GAP_W = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic len_nz;
    assign len_nz = (len != '0);

    // Single sequential FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            level   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            missed  <= 1'b0;
        end else begin
            // Event pulses last exactly one cycle unless re-asserted below.
            done   <= 1'b0;
            missed <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trig) begin
                        if (len_nz) begin
                            cnt   <= len - WIDTH'(1);
                            state <= S_ACTIVE;
                            level <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            missed <= 1'b1;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (trig && retrig_en && len_nz) begin
                        // Reload wins over a coincident end of count.
                        cnt <= len - WIDTH'(1);
                    end else begin
                        if (trig) begin
                            missed <= 1'b1;
                        end
                        if (cnt == '0) begin
                            level <= 1'b0;
                            done  <= 1'b1;
                            if (GAP != 0) begin
                                state   <= S_HOLDOFF;
                                gap_cnt <= GAP_W'(GAP - 32'd1);
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - WIDTH'(1);
                        end
                    end
                end

                S_HOLDOFF: begin
                    if (trig) begin
                        missed <= 1'b1;
                    end
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    // Unused encoding: recover to a clean idle.
                    state   <= S_IDLE;
                    cnt     <= '0;
                    gap_cnt <= '0;
                    level   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: two instances (GAP=2 and GAP=0) share
// stimulus; the driver pushes hand-computed per-cycle expectations
// {level,busy,done,missed} and a negedge monitor pops and compares them.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] len = 8'd0;
    logic       retrig_en = 1'b0;

    logic level2, busy2, done2, missed2;
    logic level0, busy0, done0, missed0;

    always #5 clk = ~clk;

    pulse_stretcher #(.WIDTH(8), .GAP(2)) u_dut_gap2 (
        .clk(clk), .rst(rst), .trig(trig), .len(len), .retrig_en(retrig_en),
        .level(level2), .busy(busy2), .done(done2), .missed(missed2)
    );

    pulse_stretcher #(.WIDTH(8), .GAP(0)) u_dut_gap0 (
        .clk(clk), .rst(rst), .trig(trig), .len(len), .retrig_en(retrig_en),
        .level(level0), .busy(busy0), .done(done0), .missed(missed0)
    );

    typedef struct {
        int         id;
        int         cyc;
        logic       chk2;
        logic [3:0] e2;
        logic       chk0;
        logic [3:0] e0;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam int NUM_SCN = 9;

    function automatic string scn_name(input int id);
        case (id)
            0: return "reset_hold";
            1: return "basic";
            2: return "retrig_on";
            3: return "retrig_off";
            4: return "len0";
            5: return "len1";
            6: return "len255";
            7: return "gap0_b2b";
            8: return "reset_mid";
            default: return "unknown";
        endcase
    endfunction

    function automatic int scn_last(input int id);
        case (id)
            0: return 12;
            1: return 27;
            2: return 21;
            3: return 18;
            4: return 5;
            5: return 7;
            6: return 262;
            7: return 20;
            8: return 23;
            default: return 0;
        endcase
    endfunction

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Stimulus and expected outputs for scenario id, cycle c (outputs seen in c).
    task automatic vec(input int id, input int c,
                       output logic r, output logic t, output logic [7:0] l,
                       output logic re, output logic ck2, output logic [3:0] e2,
                       output logic ck0, output logic [3:0] e0);
        r = 1'b1; t = 1'b0; l = 8'd0; re = 1'b0;
        ck2 = 1'b1; ck0 = 1'b1; e2 = 4'b0000; e0 = 4'b0000;
        case (id)
            0: begin
                r   = (c >= 3);
                t   = (c < 3) ? (c % 2 == 1) : (c == 3);
                l   = 8'd5;
                ck2 = (c != 0);
                ck0 = (c != 0);
                e2  = {in_rng(c, 4, 8), in_rng(c, 4, 10), c == 9, 1'b0};
                e0  = {in_rng(c, 4, 8), in_rng(c, 4, 8),  c == 9, 1'b0};
            end
            1: begin
                t  = (c == 10) || (c == 17) || (c == 18);
                l  = 8'd5;
                e2 = {in_rng(c, 11, 15) || in_rng(c, 19, 23),
                      in_rng(c, 11, 17) || in_rng(c, 19, 25),
                      (c == 16) || (c == 24), c == 18};
                e0 = {in_rng(c, 11, 15) || in_rng(c, 18, 22),
                      in_rng(c, 11, 15) || in_rng(c, 18, 22),
                      (c == 16) || (c == 23), c == 19};
            end
            2: begin
                t  = (c == 10) || (c == 13);
                l  = 8'd4;
                re = 1'b1;
                e2 = {in_rng(c, 11, 17), in_rng(c, 11, 19), c == 18, 1'b0};
                e0 = {in_rng(c, 11, 17), in_rng(c, 11, 17), c == 18, 1'b0};
            end
            3: begin
                t  = (c == 10) || (c == 13);
                l  = 8'd4;
                e2 = {in_rng(c, 11, 14), in_rng(c, 11, 16), c == 15, c == 14};
                e0 = {in_rng(c, 11, 14), in_rng(c, 11, 14), c == 15, c == 14};
            end
            4: begin
                t  = (c == 2);
                l  = 8'd0;
                e2 = {3'b000, c == 3};
                e0 = {3'b000, c == 3};
            end
            5: begin
                t  = (c == 2);
                l  = 8'd1;
                e2 = {c == 3, in_rng(c, 3, 5), c == 4, 1'b0};
                e0 = {c == 3, c == 3,          c == 4, 1'b0};
            end
            6: begin
                // len changes mid-level must not alter the running count.
                t  = (c == 2);
                l  = (c <= 2) ? 8'd255 : 8'd7;
                e2 = {in_rng(c, 3, 257), in_rng(c, 3, 259), c == 258, 1'b0};
                e0 = {in_rng(c, 3, 257), in_rng(c, 3, 257), c == 258, 1'b0};
            end
            7: begin
                t  = (c == 10) || (c == 14);
                l  = 8'd3;
                e0 = {in_rng(c, 11, 13) || in_rng(c, 15, 17),
                      in_rng(c, 11, 13) || in_rng(c, 15, 17),
                      (c == 14) || (c == 18), 1'b0};
                e2 = {in_rng(c, 11, 13), in_rng(c, 11, 15), c == 14, c == 15};
            end
            8: begin
                r  = (c != 15);
                t  = (c == 10) || (c == 16);
                l  = (c < 16) ? 8'd20 : 8'd2;
                e2 = {in_rng(c, 11, 15) || in_rng(c, 17, 18),
                      in_rng(c, 11, 15) || in_rng(c, 17, 20),
                      c == 19, 1'b0};
                e0 = {in_rng(c, 11, 15) || in_rng(c, 17, 18),
                      in_rng(c, 11, 15) || in_rng(c, 17, 18),
                      c == 19, 1'b0};
            end
            default: begin
                ck2 = 1'b0;
                ck0 = 1'b0;
            end
        endcase
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [3:0] a2;
            logic [3:0] a0;
            e  = sb.pop_front();
            a2 = {level2, busy2, done2, missed2};
            a0 = {level0, busy0, done0, missed0};
            if (e.chk2) begin
                n_cmp++;
                if (a2 !== e.e2) begin
                    n_err++;
                    $display("FAIL %s gap2 cyc=%0d got lbdm=%b exp=%b",
                             scn_name(e.id), e.cyc, a2, e.e2);
                end
            end
            if (e.chk0) begin
                n_cmp++;
                if (a0 !== e.e0) begin
                    n_err++;
                    $display("FAIL %s gap0 cyc=%0d got lbdm=%b exp=%b",
                             scn_name(e.id), e.cyc, a0, e.e0);
                end
            end
        end
    end

    initial begin
        for (int id = 0; id < NUM_SCN; id++) begin
            for (int c = 0; c <= scn_last(id); c++) begin
                logic       r, t, re, ck2, ck0;
                logic [7:0] l;
                logic [3:0] e2, e0;
                exp_t       ent;
                vec(id, c, r, t, l, re, ck2, e2, ck0, e0);
                @(posedge clk);
                #1;
                rst       = r;
                trig      = t;
                len       = l;
                retrig_en = re;
                ent.id   = id;
                ent.cyc  = c;
                ent.chk2 = ck2;
                ent.e2   = e2;
                ent.chk0 = ck0;
                ent.e0   = e0;
                sb.push_back(ent);
            end
        end
        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Inverse companion to the positive-edge detector. That block turns a level into a one-cycle pulse; this one turns a one-cycle pulse back into a level.
- Each accepted trigger pulse produces an output level held high for a programmable number of clk cycles. An optional hold-off gap follows each level, and retriggering is supported.
- Used after edge detectors to drive LEDs, enables and timed strobes in the project datapath.

Parameters:
- WIDTH, 8, width of the len input and of the internal down-counter.
- GAP, 2, hold-off cycles after each output level during which triggers are ignored; 0 means no hold-off.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset: rst==0 at a rising clk edge resets the block.
- trig  input  1  trigger; sampled every rising edge; normally a one-cycle pulse from an edge detector.
- len  input  WIDTH  output level length in cycles, sampled when a trigger is accepted.
- retrig_en  input  1  1 means a trigger during ACTIVE reloads the counter.
- level  output  1  stretched output (registered).
- busy  output  1  high in ACTIVE and HOLDOFF.
- done  output  1  one-cycle pulse when level falls.
- missed  output  1  one-cycle pulse when a trigger is ignored.

Behaviour:
- Reset: rst==0 at an edge gives state=IDLE, cnt=0, gap counter=0, level=0, busy=0, done=0, missed=0. Reset overrides everything, including mid-level or mid-hold-off; level drops the cycle after.
- All outputs are registered. Timing below is in cycles, with trig high in cycle n sampled at the end of n.
- IDLE:
  - trig=1 and len!=0: cnt<=len-1, go to ACTIVE. level is high in cycles n+1 through n+len, exactly len cycles.
  - trig=1 and len==0: stay IDLE, missed=1 in n+1.
- ACTIVE (level=1, busy=1):
  - trig=1 and retrig_en=1 and len!=0 in cycle m: cnt<=len-1 using the current len. level stays high through m+len with no gap.
  - Any other trig=1 (retrig_en=0 or len==0): ignored, counting continues, missed=1 next cycle.
  - Else if cnt==0: leave ACTIVE. Go to HOLDOFF with gap counter=GAP-1 if GAP>0, else to IDLE. In the following cycle level=0 and done=1.
  - Else cnt<=cnt-1.
  - When the reload and cnt==0 coincide, the reload wins; there is no done pulse.
- HOLDOFF (level=0, busy=1):
  - trig ignored, missed=1 next cycle.
  - Gap counter decrements; at 0 go to IDLE.
  - For a level ending in cycle e: done is high in e+1, HOLDOFF spans e+1..e+GAP, and the first acceptable trigger is in cycle e+GAP+1.
- GAP=0: a trigger in cycle e+1 is accepted, giving level low for exactly one cycle (e+1) before going high again. A trigger in the last ACTIVE cycle e is treated per the ACTIVE rules.
- len=all-ones (255): 255-cycle level, no wrap. The counter only ever loads len-1 or decrements from a nonzero value; it never underflows.
- Changes to len during ACTIVE do not affect the running count unless a retrigger occurs.
- done and missed are never asserted for more than one consecutive cycle per event. done and level are never both 1.
- Unused state encodings recover to IDLE next cycle.

Test Plan:
- Reset hold: rst=0 for 3 cycles with trig toggling -> level=busy=done=missed=0 throughout; first trig after release is accepted normally.
- Basic stretch: GAP=2, len=5, trig in cycle 10 -> level high cycles 11-15, done=1 in 16, busy high 11-17, trig in 17 gives missed=1 in 18, trig in 18 accepted (level high 19-23).
- Retrigger: len=4, retrig_en=1, trig in 10 and 13 -> level continuous 11-17, single done in 18; repeat with retrig_en=0 -> level 11-14, missed=1 in 14, done in 15.
- Boundaries: len=0 trig in IDLE -> no level, missed=1 next cycle; len=1 -> one-cycle level; len=255 -> 255-cycle level, done in cycle n+256.
- GAP=0 back-to-back: len=3, trigs in 10 and 14 -> level 11-13, low in 14, high 15-17; done in 14 and 18.
- Reset mid-operation: len=20, trig in 10, rst=0 in cycle 15 -> level=0 from 16, no done, IDLE accepts trig in 16 after rst=1.
